// File: rtl/led_matrix_scheduler.sv
// Round-robin shared 4x4 LED frame register with row-scanned, dead-timed matrix drive.
// Optional PWM brightness per row slot is enabled by defining LED_SCHED_BRIGHTNESS_EN.
module led_matrix_scheduler #(
   parameter int NREQ     = 4,
   parameter int SCAN_DIV = 12000,
   parameter int DEADTIME = 48
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef LED_SCHED_BRIGHTNESS_EN
   input  logic [3:0]           bright,
`endif
   input  logic [NREQ-1:0]      req_valid,
   input  logic [16*NREQ-1:0]   req_mask,
   input  logic [16*NREQ-1:0]   req_bits,
   output logic [NREQ-1:0]      req_ready,
   output logic [15:0]          frame,
   output logic [3:0]           aled,
   output logic [3:0]           kled_tri,
   output logic [1:0]           row
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(SCAN_DIV);

   typedef enum logic {BLANK, DRIVE} scanState_e;

   logic [PW-1:0]    r_rrPtr;
   logic [15:0]      r_frame;
   logic [15:0]      r_shadow;
   logic [CW-1:0]    r_slotCnt;
   logic [1:0]       r_row;
   logic [3:0]       r_aled;
   logic [3:0]       r_kled;
   scanState_e       r_state;

   logic [NREQ-1:0]  w_grant;
   logic             w_xfer;
   logic [PW-1:0]    w_grantIdx;
   logic [15:0]      w_selMask;
   logic [15:0]      w_selBits;
   logic [3:0]       w_rowBits;
   logic             w_slotEnd;

   // First valid requester at or after the pointer wins, wrapping around.
   always_comb begin
      w_grant    = '0;
      w_xfer     = 1'b0;
      w_grantIdx = '0;
      w_selMask  = '0;
      w_selBits  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_xfer && req_valid[(int'(r_rrPtr) + k) % NREQ]) begin
            w_xfer = 1'b1;
            w_grant[(int'(r_rrPtr) + k) % NREQ] = 1'b1;
            w_grantIdx = PW'((int'(r_rrPtr) + k) % NREQ);
            w_selMask  = req_mask[((int'(r_rrPtr) + k) % NREQ) * 16 +: 16];
            w_selBits  = req_bits[((int'(r_rrPtr) + k) % NREQ) * 16 +: 16];
         end
      end
   end

   assign req_ready = rst_n ? w_grant : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame <= '0;
         r_rrPtr <= '0;
      end else if (w_xfer) begin
         r_frame <= (r_frame & ~w_selMask) | (w_selBits & w_selMask);
         r_rrPtr <= (w_grantIdx == PW'(NREQ - 1)) ? '0 : w_grantIdx + 1'b1;
      end
   end

   assign w_rowBits = r_shadow[r_row * 4 +: 4];
   assign w_slotEnd = (r_slotCnt == CW'(SCAN_DIV - 1));

`ifdef LED_SCHED_BRIGHTNESS_EN
   localparam int SUB = (SCAN_DIV - DEADTIME) / 16;
   localparam int SW  = (SUB > 1) ? $clog2(SUB) : 1;

   if (((SCAN_DIV - DEADTIME) % 16) != 0) begin : g_badDriveWindow
      $error("led_matrix_scheduler: SCAN_DIV-DEADTIME must be a multiple of 16");
   end

   logic [SW-1:0] r_subCnt;
   logic [3:0]    r_subIdx;
   logic [3:0]    r_bright;
`endif

   // Outputs are computed one edge ahead so the row change always lands in blanking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow  <= '0;
         r_slotCnt <= '0;
         r_row     <= '0;
         r_aled    <= '0;
         r_kled    <= '0;
         r_state   <= BLANK;
`ifdef LED_SCHED_BRIGHTNESS_EN
         r_subCnt  <= '0;
         r_subIdx  <= '0;
         r_bright  <= '0;
`endif
      end else if (w_slotEnd) begin
         r_slotCnt <= '0;
         r_row     <= r_row + 2'd1;
         r_aled    <= '0;
         r_kled    <= '0;
         r_state   <= BLANK;
         if (r_row == 2'd3) r_shadow <= r_frame;
`ifdef LED_SCHED_BRIGHTNESS_EN
         r_bright  <= bright;
`endif
      end else begin
         r_slotCnt <= r_slotCnt + 1'b1;
         if (r_state == BLANK) begin
            if (r_slotCnt == CW'(DEADTIME - 1)) begin
               r_state <= DRIVE;
               r_aled  <= 4'b0001 << r_row;
               r_kled  <= w_rowBits;
`ifdef LED_SCHED_BRIGHTNESS_EN
               r_subCnt <= '0;
               r_subIdx <= '0;
`endif
            end
         end else begin
`ifdef LED_SCHED_BRIGHTNESS_EN
            // Subslot 0 is always lit; later subslots only while index <= brightness.
            if (r_subCnt == SW'(SUB - 1)) begin
               r_subCnt <= '0;
               r_subIdx <= r_subIdx + 4'd1;
               r_kled   <= ((r_subIdx + 4'd1) <= r_bright) ? w_rowBits : 4'b0000;
            end else begin
               r_subCnt <= r_subCnt + 1'b1;
            end
`else
            r_kled <= w_rowBits;
`endif
         end
      end
   end

   assign frame    = r_frame;
   assign aled     = r_aled;
   assign kled_tri = r_kled;
   assign row      = r_row;

endmodule

// File: tb/tb_led_matrix_scheduler.sv
// Bench for led_matrix_scheduler: directed steps plus random requesters against a time-based model.
// Builds with or without LED_SCHED_BRIGHTNESS_EN.
module tb_led_matrix_scheduler;

   localparam int NREQ     = 4;
   localparam int SCAN_DIV = 36;
   localparam int DEADTIME = 4;
   localparam int FRAME_T  = 4 * SCAN_DIV;
   localparam int SUB      = (SCAN_DIV - DEADTIME) / 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      valid;
   logic [16*NREQ-1:0]   mask;
   logic [16*NREQ-1:0]   bits;
   logic [NREQ-1:0]      ready;
   logic [15:0]          frame;
   logic [3:0]           aled;
   logic [3:0]           kled;
   logic [1:0]           row;
`ifdef LED_SCHED_BRIGHTNESS_EN
   logic [3:0]           bright;
`endif

   int errors = 0;
   int checks = 0;

   int          modelT;
   logic [15:0] modelFrame;
   logic [15:0] modelShadow;
   int          modelPtr;
   int          lastGrant;
   int          modelBright;

   led_matrix_scheduler #(
      .NREQ(NREQ), .SCAN_DIV(SCAN_DIV), .DEADTIME(DEADTIME)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef LED_SCHED_BRIGHTNESS_EN
      .bright(bright),
`endif
      .req_valid(valid),
      .req_mask(mask),
      .req_bits(bits),
      .req_ready(ready),
      .frame(frame),
      .aled(aled),
      .kled_tri(kled),
      .row(row)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0d)", tag, observed, expected, modelT);
      end
   endtask

   function automatic int pickGrant(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++)
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [16*NREQ-1:0] slice(input int idx, input logic [15:0] val);
      logic [16*NREQ-1:0] res;
      res = '0;
      res[idx*16 +: 16] = val;
      return res;
   endfunction

   task automatic modelReset();
      modelT      = 0;
      modelFrame  = '0;
      modelShadow = '0;
      modelPtr    = 0;
      lastGrant   = -1;
      modelBright = 0;
   endtask

   // Display timing follows purely from elapsed cycles since reset release.
   task automatic checkAll();
      int off;
      int r;
      int g;
      logic [3:0] expA;
      logic [3:0] expK;
      logic [NREQ-1:0] expR;
      off  = modelT % SCAN_DIV;
      r    = (modelT / SCAN_DIV) % 4;
      expA = '0;
      expK = '0;
      if (off >= DEADTIME) begin
         expA = 4'b0001 << r;
         expK = modelShadow[r*4 +: 4];
`ifdef LED_SCHED_BRIGHTNESS_EN
         if (((off - DEADTIME) / SUB) > modelBright) expK = '0;
`endif
      end
      g    = pickGrant(valid, modelPtr);
      expR = '0;
      if (g >= 0) expR[g] = 1'b1;
      checkOutput("req_ready", 64'(ready), 64'(expR));
      checkOutput("frame",     64'(frame), 64'(modelFrame));
      checkOutput("aled",      64'(aled),  64'(expA));
      checkOutput("kled_tri",  64'(kled),  64'(expK));
      checkOutput("row",       64'(row),   64'(r));
   endtask

   task automatic modelEdge();
      logic [15:0] m;
      logic [15:0] b;
      if (((modelT + 1) % FRAME_T) == 0) modelShadow = modelFrame;
`ifdef LED_SCHED_BRIGHTNESS_EN
      if (((modelT + 1) % SCAN_DIV) == 0) modelBright = int'(bright);
`endif
      lastGrant = pickGrant(valid, modelPtr);
      if (lastGrant >= 0) begin
         m = mask[lastGrant*16 +: 16];
         b = bits[lastGrant*16 +: 16];
         modelFrame = (modelFrame & ~m) | (b & m);
         modelPtr   = (lastGrant + 1) % NREQ;
      end
      modelT++;
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [16*NREQ-1:0] m,
                                input logic [16*NREQ-1:0] b);
      valid = v;
      mask  = m;
      bits  = b;
      @(negedge clk);
      checkAll();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic runIdle(input int n);
      repeat (n) applyStimulus('0, '0, '0);
   endtask

   logic [NREQ-1:0]    rv;
   logic [16*NREQ-1:0] rm;
   logic [16*NREQ-1:0] rb;

   initial begin
      rst_n = 1'b0;
      valid = '0;
      mask  = '0;
      bits  = '0;
`ifdef LED_SCHED_BRIGHTNESS_EN
      bright = 4'd3;
`endif
      modelReset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single full-mask write; visible one scan after the next wrap.
      applyStimulus(4'b0001, slice(0, 16'hFFFF), slice(0, 16'h0420));
      checkOutput("single write frame", 64'(frame), 64'h0420);
      runIdle(2 * FRAME_T - 2);

      // Zero-mask transfer leaves the frame alone and moves the pointer back to 0.
      applyStimulus(4'b1000, slice(3, 16'h0000), slice(3, 16'hFFFF));
      checkOutput("zero mask frame", 64'(frame), 64'h0420);

      // All four requesting: grants rotate 0,1,2,3,0,1.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'hF, {16'hF000, 16'h0F00, 16'h00F0, 16'h000F}, {4{16'hFFFF}});
         if (i == 3) checkOutput("round robin frame", 64'(frame), 64'hFFFF);
      end

      applyStimulus(4'b0100, slice(2, 16'h00F0), slice(2, 16'h0000));
      checkOutput("partial mask", 64'(frame), 64'hFF0F);

      // Write during row 2, then a write exactly on the wrap edge.
      for (int n = 0; n < FRAME_T && ((modelT / SCAN_DIV) % 4) != 2; n++) runIdle(1);
      applyStimulus(4'b0010, slice(1, 16'hFFFF), slice(1, 16'h0001));
      for (int n = 0; n < FRAME_T && (modelT % FRAME_T) != FRAME_T - 1; n++) runIdle(1);
      applyStimulus(4'b0001, slice(0, 16'hFFFF), slice(0, 16'h0008));
      runIdle(2 * FRAME_T + 10);

      // Random requesters that hold their request until granted or randomly withdraw.
      rv = '0;
      rm = '0;
      rb = '0;
      for (int c = 0; c < 900; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (rv[i]) begin
               if (lastGrant == i || $urandom_range(7) == 0) rv[i] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
               rv[i] = 1'b1;
               rm[i*16 +: 16] = ($urandom_range(5) == 0) ? 16'h0000 : 16'($urandom);
               rb[i*16 +: 16] = 16'($urandom);
            end
         end
`ifdef LED_SCHED_BRIGHTNESS_EN
         if ($urandom_range(15) == 0) bright = 4'($urandom_range(15));
`endif
         applyStimulus(rv, rm, rb);
      end

      // Asynchronous reset in the middle of a DRIVE window.
      for (int n = 0; n < SCAN_DIV && (modelT % SCAN_DIV) != SCAN_DIV / 2; n++) runIdle(1);
      valid = 4'hF;
      mask  = {4{16'hFFFF}};
      bits  = {4{16'hA5A5}};
      rst_n = 1'b0;
      #1;
      checkOutput("reset aled",      64'(aled),  64'h0);
      checkOutput("reset kled_tri",  64'(kled),  64'h0);
      checkOutput("reset frame",     64'(frame), 64'h0);
      checkOutput("reset req_ready", 64'(ready), 64'h0);
      checkOutput("reset row",       64'(row),   64'h0);
      modelReset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(4'b0001, slice(0, 16'h00FF), slice(0, 16'h0081));
      runIdle(2 * FRAME_T + 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
